// File: rtl/mem_except_if.sv
// EX->MEM stage bundle for mem_except.
// slave  : the mem_except stage (consumes EX/CP0/WB inputs, drives MEM outputs)
// master : the surrounding pipeline (drives EX/CP0/WB inputs, consumes MEM outputs)
interface mem_except_if;

  // Pipeline control
  logic        ex_stall_i;
  logic        mem_stall_i;

  // EX-stage result
  logic [4:0]  ex_wd_i;
  logic        ex_wreg_i;
  logic [31:0] ex_wdata_i;
  logic        ex_cp0_we_i;
  logic [4:0]  ex_cp0_waddr_i;
  logic [31:0] ex_cp0_wdata_i;
  logic [3:0]  ex_except_i;
  logic [31:0] ex_inst_addr_i;
  logic        ex_in_delayslot_i;

  // Current CP0 state
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;

  // WB-stage CP0 write, forwarded into exception resolution
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_wdata_i;

  // MEM-stage outputs
  logic [4:0]  mem_wd_o;
  logic        mem_wreg_o;
  logic [31:0] mem_wdata_o;
  logic        mem_cp0_we_o;
  logic [4:0]  mem_cp0_waddr_o;
  logic [31:0] mem_cp0_wdata_o;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_address_o;
  logic        is_in_delayslot_o;
  logic [31:0] cp0_epc_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  modport slave (
    input  ex_stall_i, mem_stall_i,
    input  ex_wd_i, ex_wreg_i, ex_wdata_i,
    input  ex_cp0_we_i, ex_cp0_waddr_i, ex_cp0_wdata_i,
    input  ex_except_i, ex_inst_addr_i, ex_in_delayslot_i,
    input  cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i,
    output mem_wd_o, mem_wreg_o, mem_wdata_o,
    output mem_cp0_we_o, mem_cp0_waddr_o, mem_cp0_wdata_o,
    output excepttype_o, current_inst_address_o, is_in_delayslot_o,
    output cp0_epc_o, flush_o, new_pc_o
  );

  modport master (
    output ex_stall_i, mem_stall_i,
    output ex_wd_i, ex_wreg_i, ex_wdata_i,
    output ex_cp0_we_i, ex_cp0_waddr_i, ex_cp0_wdata_i,
    output ex_except_i, ex_inst_addr_i, ex_in_delayslot_i,
    output cp0_status_i, cp0_cause_i, cp0_epc_i,
    output wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i,
    input  mem_wd_o, mem_wreg_o, mem_wdata_o,
    input  mem_cp0_we_o, mem_cp0_waddr_o, mem_cp0_wdata_o,
    input  excepttype_o, current_inst_address_o, is_in_delayslot_o,
    input  cp0_epc_o, flush_o, new_pc_o
  );

endinterface

// File: rtl/mem_except.sv
// EX/MEM pipeline register plus MEM-stage exception resolver.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - mem_except_if.slave: EX result/flags, CP0 state, WB CP0 write in;
//          MEM GPR/CP0 write, exception code, faulting PC, flush and restart PC out.
// Exception outputs are combinational from the stage register and the
// forwarded CP0 state so cp0_reg can commit at the next edge.
module mem_except (
  input  logic         clk,
  input  logic         rst,
  mem_except_if.slave  bus
);

  localparam int unsigned REG_W  = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned EXC_W  = 4;

  localparam logic [ADDR_W-1:0] CP0_STATUS = 5'd12;
  localparam logic [ADDR_W-1:0] CP0_CAUSE  = 5'd13;
  localparam logic [ADDR_W-1:0] CP0_EPC    = 5'd14;

  localparam logic [REG_W-1:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [REG_W-1:0] EXC_INT     = 32'h0000_0001;
  localparam logic [REG_W-1:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [REG_W-1:0] EXC_INVALID = 32'h0000_000a;
  localparam logic [REG_W-1:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [REG_W-1:0] EXC_ERET    = 32'h0000_000e;

  localparam logic [REG_W-1:0] EXC_VECTOR  = 32'h0000_0020;

  // Bit positions inside the {eret, trap, invalid, syscall} flag vector
  localparam int unsigned F_SYSCALL = 0;
  localparam int unsigned F_INVALID = 1;
  localparam int unsigned F_TRAP    = 2;
  localparam int unsigned F_ERET    = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [REG_W-1:0]  wdata;
    logic              cp0_we;
    logic [ADDR_W-1:0] cp0_waddr;
    logic [REG_W-1:0]  cp0_wdata;
    logic [EXC_W-1:0]  except_flags;
    logic [REG_W-1:0]  inst_addr;
    logic              in_delayslot;
  } stage_t;

  stage_t            r_stage;
  stage_t            w_ex;

  logic [REG_W-1:0]  w_status_fwd;
  logic [REG_W-1:0]  w_cause_fwd;
  logic [REG_W-1:0]  w_epc_fwd;
  logic              w_int_pending;
  logic              w_slot_valid;
  logic [REG_W-1:0]  w_excepttype;
  logic              w_flush;
  logic              w_unused_ok;

  // Pack the EX-stage inputs into one stage record
  always_comb begin
    w_ex              = '0;
    w_ex.wd           = bus.ex_wd_i;
    w_ex.wreg         = bus.ex_wreg_i;
    w_ex.wdata        = bus.ex_wdata_i;
    w_ex.cp0_we       = bus.ex_cp0_we_i;
    w_ex.cp0_waddr    = bus.ex_cp0_waddr_i;
    w_ex.cp0_wdata    = bus.ex_cp0_wdata_i;
    w_ex.except_flags = bus.ex_except_i;
    w_ex.inst_addr    = bus.ex_inst_addr_i;
    w_ex.in_delayslot = bus.ex_in_delayslot_i;
  end

  // Stage register: flush beats stall so a faulting instruction never lingers
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_stage <= '0;
    end else if (bus.ex_stall_i && !bus.mem_stall_i) begin
      r_stage <= '0;
    end else if (!bus.mem_stall_i) begin
      r_stage <= w_ex;
    end
  end

  // WB->MEM CP0 forwarding; Cause only exposes the software-writable IP bits and IV/WP
  always_comb begin
    w_status_fwd = bus.cp0_status_i;
    w_cause_fwd  = bus.cp0_cause_i;
    w_epc_fwd    = bus.cp0_epc_i;
    if (bus.wb_cp0_we_i) begin
      if (bus.wb_cp0_waddr_i == CP0_STATUS) begin
        w_status_fwd = bus.wb_cp0_wdata_i;
      end
      if (bus.wb_cp0_waddr_i == CP0_CAUSE) begin
        w_cause_fwd[9:8] = bus.wb_cp0_wdata_i[9:8];
        w_cause_fwd[22]  = bus.wb_cp0_wdata_i[22];
        w_cause_fwd[23]  = bus.wb_cp0_wdata_i[23];
      end
      if (bus.wb_cp0_waddr_i == CP0_EPC) begin
        w_epc_fwd = bus.wb_cp0_wdata_i;
      end
    end
  end

  // Interrupt needs an unmasked pending line, IE set and EXL clear
  assign w_int_pending = ((w_cause_fwd[15:8] & w_status_fwd[15:8]) != 8'h00) &&
                         w_status_fwd[0] && !w_status_fwd[1];

  // A bubble carries address 0 and must never trap
  assign w_slot_valid = (r_stage.inst_addr != '0);

  // Prioritised exception code
  always_comb begin
    w_excepttype = EXC_NONE;
    if (w_slot_valid) begin
      if (w_int_pending) begin
        w_excepttype = EXC_INT;
      end else if (r_stage.except_flags[F_SYSCALL]) begin
        w_excepttype = EXC_SYSCALL;
      end else if (r_stage.except_flags[F_INVALID]) begin
        w_excepttype = EXC_INVALID;
      end else if (r_stage.except_flags[F_TRAP]) begin
        w_excepttype = EXC_TRAP;
      end else if (r_stage.except_flags[F_ERET]) begin
        w_excepttype = EXC_ERET;
      end
    end
  end

  assign w_flush = (w_excepttype != EXC_NONE);

  // Status/Cause bits that play no part in exception resolution
  assign w_unused_ok = &{1'b0, w_status_fwd[31:16], w_status_fwd[7:2],
                         w_cause_fwd[31:16], w_cause_fwd[7:0]};

  // GPR/CP0 writes of the faulting instruction are squashed; data stays visible
  assign bus.mem_wd_o        = r_stage.wd;
  assign bus.mem_wreg_o      = r_stage.wreg & ~w_flush;
  assign bus.mem_wdata_o     = r_stage.wdata;
  assign bus.mem_cp0_we_o    = r_stage.cp0_we & ~w_flush;
  assign bus.mem_cp0_waddr_o = r_stage.cp0_waddr;
  assign bus.mem_cp0_wdata_o = r_stage.cp0_wdata;

  assign bus.excepttype_o           = w_excepttype;
  assign bus.current_inst_address_o = r_stage.inst_addr;
  assign bus.is_in_delayslot_o      = r_stage.in_delayslot;
  assign bus.cp0_epc_o              = w_epc_fwd;
  assign bus.flush_o                = w_flush;

  // eret returns to EPC; every other exception enters the common vector
  assign bus.new_pc_o = (w_excepttype == EXC_ERET) ? w_epc_fwd : EXC_VECTOR;

endmodule

// File: tb/tb_mem_except.sv
// Directed testbench for mem_except: vector table for single-instruction
// exception resolution plus hand-written sequences for stall/flush/reset.
module tb_mem_except;

  logic clk;
  logic rst;

  mem_except_if bus ();

  mem_except dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  exc;
    logic        ds;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] e_type;
    logic [31:0] e_newpc;
    logic [31:0] e_epc;
    logic        e_we;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [31:0] addr, input logic [3:0] exc, input logic ds,
    input logic [31:0] status, input logic [31:0] cause, input logic [31:0] epc,
    input logic wb_we, input logic [4:0] wb_addr, input logic [31:0] wb_data,
    input logic [31:0] e_type, input logic [31:0] e_newpc, input logic [31:0] e_epc,
    input logic e_we);
    vec_t v;
    v.addr = addr; v.exc = exc; v.ds = ds;
    v.status = status; v.cause = cause; v.epc = epc;
    v.wb_we = wb_we; v.wb_addr = wb_addr; v.wb_data = wb_data;
    v.e_type = e_type; v.e_newpc = e_newpc; v.e_epc = e_epc; v.e_we = e_we;
    return v;
  endfunction

  task automatic drive_ex(input logic [31:0] addr, input logic [3:0] exc,
                          input logic ds, input logic [31:0] wdata, input logic [4:0] wd);
    bus.ex_wd_i           = wd;
    bus.ex_wreg_i         = 1'b1;
    bus.ex_wdata_i        = wdata;
    bus.ex_cp0_we_i       = 1'b1;
    bus.ex_cp0_waddr_i    = 5'd11;
    bus.ex_cp0_wdata_i    = 32'h0000_5a5a;
    bus.ex_except_i       = exc;
    bus.ex_inst_addr_i    = addr;
    bus.ex_in_delayslot_i = ds;
  endtask

  task automatic clear_ex();
    bus.ex_wd_i           = 5'd0;
    bus.ex_wreg_i         = 1'b0;
    bus.ex_wdata_i        = 32'h0;
    bus.ex_cp0_we_i       = 1'b0;
    bus.ex_cp0_waddr_i    = 5'd0;
    bus.ex_cp0_wdata_i    = 32'h0;
    bus.ex_except_i       = 4'b0000;
    bus.ex_inst_addr_i    = 32'h0;
    bus.ex_in_delayslot_i = 1'b0;
  endtask

  task automatic set_cp0(input logic [31:0] status, input logic [31:0] cause,
                         input logic [31:0] epc, input logic wb_we,
                         input logic [4:0] wb_addr, input logic [31:0] wb_data);
    bus.cp0_status_i   = status;
    bus.cp0_cause_i    = cause;
    bus.cp0_epc_i      = epc;
    bus.wb_cp0_we_i    = wb_we;
    bus.wb_cp0_waddr_i = wb_addr;
    bus.wb_cp0_wdata_i = wb_data;
  endtask

  initial begin
    // addr, exc, ds, status, cause, epc, wb_we, wb_addr, wb_data, e_type, e_newpc, e_epc, e_we
    vecs[0]  = mk(32'h100, 4'b0000, 1'b0, 32'hFF01, 32'h400, 32'h0,   1'b0, 5'd0,  32'h0,    32'h1, 32'h20,  32'h0,   1'b0);
    vecs[1]  = mk(32'h104, 4'b0000, 1'b0, 32'hFF01, 32'h0,   32'h0,   1'b0, 5'd0,  32'h0,    32'h0, 32'h20,  32'h0,   1'b1);
    vecs[2]  = mk(32'h108, 4'b1111, 1'b0, 32'h0,    32'h0,   32'h0,   1'b0, 5'd0,  32'h0,    32'h8, 32'h20,  32'h0,   1'b0);
    vecs[3]  = mk(32'h10C, 4'b1111, 1'b0, 32'hFF01, 32'h400, 32'h0,   1'b0, 5'd0,  32'h0,    32'h1, 32'h20,  32'h0,   1'b0);
    vecs[4]  = mk(32'h110, 4'b0010, 1'b0, 32'h0,    32'h0,   32'h0,   1'b0, 5'd0,  32'h0,    32'ha, 32'h20,  32'h0,   1'b0);
    vecs[5]  = mk(32'h114, 4'b0100, 1'b0, 32'h0,    32'h0,   32'h0,   1'b0, 5'd0,  32'h0,    32'hd, 32'h20,  32'h0,   1'b0);
    vecs[6]  = mk(32'h118, 4'b1000, 1'b0, 32'h0,    32'h0,   32'h300, 1'b0, 5'd0,  32'h0,    32'he, 32'h300, 32'h300, 1'b0);
    vecs[7]  = mk(32'h11C, 4'b1000, 1'b0, 32'h0,    32'h0,   32'h300, 1'b1, 5'd14, 32'h400,  32'he, 32'h400, 32'h400, 1'b0);
    vecs[8]  = mk(32'h120, 4'b0000, 1'b0, 32'hFF03, 32'h400, 32'h0,   1'b0, 5'd0,  32'h0,    32'h0, 32'h20,  32'h0,   1'b1);
    vecs[9]  = mk(32'h124, 4'b0000, 1'b0, 32'hFF01, 32'h400, 32'h0,   1'b1, 5'd12, 32'h0,    32'h0, 32'h20,  32'h0,   1'b1);
    vecs[10] = mk(32'h0,   4'b1111, 1'b0, 32'hFF01, 32'h400, 32'h0,   1'b0, 5'd0,  32'h0,    32'h0, 32'h20,  32'h0,   1'b1);
    vecs[11] = mk(32'h128, 4'b0000, 1'b0, 32'hFF01, 32'h0,   32'h0,   1'b1, 5'd13, 32'h200,  32'h1, 32'h20,  32'h0,   1'b0);
    vecs[12] = mk(32'h12C, 4'b0000, 1'b0, 32'hFF01, 32'h0,   32'h0,   1'b1, 5'd13, 32'h8000, 32'h0, 32'h20,  32'h0,   1'b1);
    vecs[13] = mk(32'h130, 4'b0000, 1'b0, 32'hFF00, 32'h400, 32'h0,   1'b0, 5'd0,  32'h0,    32'h0, 32'h20,  32'h0,   1'b1);
    vecs[14] = mk(32'h204, 4'b0100, 1'b1, 32'h0,    32'h0,   32'h0,   1'b0, 5'd0,  32'h0,    32'hd, 32'h20,  32'h0,   1'b0);
    vecs[15] = mk(32'h134, 4'b0000, 1'b0, 32'h0,    32'h400, 32'h0,   1'b1, 5'd12, 32'hFF01, 32'h1, 32'h20,  32'h0,   1'b0);
    vecs[16] = mk(32'h138, 4'b1000, 1'b0, 32'h0,    32'h0,   32'h300, 1'b0, 5'd14, 32'h400,  32'he, 32'h300, 32'h300, 1'b0);
    vecs[17] = mk(32'h13C, 4'b1000, 1'b0, 32'hFF01, 32'h400, 32'h300, 1'b0, 5'd0,  32'h0,    32'h1, 32'h20,  32'h300, 1'b0);

    // Reset state
    rst = 1'b1;
    bus.ex_stall_i  = 1'b0;
    bus.mem_stall_i = 1'b0;
    clear_ex();
    set_cp0(32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset excepttype", bus.excepttype_o, 32'h0);
    chk("reset flush", 32'(bus.flush_o), 32'h0);
    chk("reset new_pc", bus.new_pc_o, 32'h20);
    chk("reset inst_addr", bus.current_inst_address_o, 32'h0);
    chk("reset wreg", 32'(bus.mem_wreg_o), 32'h0);
    chk("reset wdata", bus.mem_wdata_o, 32'h0);
    chk("reset epc", bus.cp0_epc_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table: each vector sits in MEM for one cycle, separated by a bubble cycle
    for (int i = 0; i < NV; i++) begin
      drive_ex(vecs[i].addr, vecs[i].exc, vecs[i].ds,
               vecs[i].addr ^ 32'hDEAD_0000, 5'(i + 1));
      @(posedge clk);
      #1;
      set_cp0(vecs[i].status, vecs[i].cause, vecs[i].epc,
              vecs[i].wb_we, vecs[i].wb_addr, vecs[i].wb_data);
      #1;
      chk($sformatf("v%0d excepttype", i), bus.excepttype_o, vecs[i].e_type);
      chk($sformatf("v%0d flush", i), 32'(bus.flush_o), 32'(vecs[i].e_type != 32'h0));
      chk($sformatf("v%0d new_pc", i), bus.new_pc_o, vecs[i].e_newpc);
      chk($sformatf("v%0d cp0_epc", i), bus.cp0_epc_o, vecs[i].e_epc);
      chk($sformatf("v%0d wreg", i), 32'(bus.mem_wreg_o), 32'(vecs[i].e_we));
      chk($sformatf("v%0d cp0_we", i), 32'(bus.mem_cp0_we_o), 32'(vecs[i].e_we));
      chk($sformatf("v%0d wdata", i), bus.mem_wdata_o, vecs[i].addr ^ 32'hDEAD_0000);
      chk($sformatf("v%0d wd", i), 32'(bus.mem_wd_o), 32'(i + 1));
      chk($sformatf("v%0d cp0_wdata", i), bus.mem_cp0_wdata_o, 32'h0000_5a5a);
      chk($sformatf("v%0d inst_addr", i), bus.current_inst_address_o, vecs[i].addr);
      chk($sformatf("v%0d delayslot", i), 32'(bus.is_in_delayslot_o), 32'(vecs[i].ds));
      @(negedge clk);
      clear_ex();
      set_cp0(32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
    end

    // Flush is one cycle: the instruction behind the faulting one is dropped
    drive_ex(32'h100, 4'b0000, 1'b0, 32'h1111_0000, 5'd3);
    set_cp0(32'hFF01, 32'h400, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge clk);
    #1;
    chk("seqA flush", 32'(bus.flush_o), 32'h1);
    @(negedge clk);
    drive_ex(32'h108, 4'b0000, 1'b0, 32'h2222_0000, 5'd4);
    @(posedge clk);
    #1;
    chk("seqA next flush", 32'(bus.flush_o), 32'h0);
    chk("seqA next inst_addr", bus.current_inst_address_o, 32'h0);
    chk("seqA next wdata", bus.mem_wdata_o, 32'h0);
    @(negedge clk);
    clear_ex();
    set_cp0(32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);

    // Flush together with a MEM stall still bubbles the stage
    drive_ex(32'h150, 4'b0001, 1'b0, 32'h3333_0000, 5'd5);
    @(posedge clk);
    #1;
    chk("seqE excepttype", bus.excepttype_o, 32'h8);
    @(negedge clk);
    clear_ex();
    bus.mem_stall_i = 1'b1;
    @(posedge clk);
    #1;
    chk("seqE inst_addr", bus.current_inst_address_o, 32'h0);
    chk("seqE flush", 32'(bus.flush_o), 32'h0);
    @(negedge clk);
    bus.mem_stall_i = 1'b0;
    @(negedge clk);

    // MEM stall holds for 3 cycles, then an EX-only stall inserts a bubble
    drive_ex(32'h140, 4'b0000, 1'b0, 32'hAAAA_5555, 5'd7);
    @(posedge clk);
    #1;
    chk("seqB capture", bus.current_inst_address_o, 32'h140);
    @(negedge clk);
    bus.mem_stall_i = 1'b1;
    drive_ex(32'h160, 4'b0000, 1'b0, 32'h0, 5'd9);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("seqB hold%0d inst_addr", k), bus.current_inst_address_o, 32'h140);
      chk($sformatf("seqB hold%0d wdata", k), bus.mem_wdata_o, 32'hAAAA_5555);
      chk($sformatf("seqB hold%0d wd", k), 32'(bus.mem_wd_o), 32'd7);
    end
    @(negedge clk);
    bus.mem_stall_i = 1'b0;
    bus.ex_stall_i  = 1'b1;
    @(posedge clk);
    #1;
    chk("seqB bubble inst_addr", bus.current_inst_address_o, 32'h0);
    chk("seqB bubble wdata", bus.mem_wdata_o, 32'h0);
    chk("seqB bubble wreg", 32'(bus.mem_wreg_o), 32'h0);
    @(negedge clk);
    bus.ex_stall_i = 1'b0;

    // Reset during a hold clears the held instruction
    drive_ex(32'h180, 4'b0000, 1'b1, 32'hBBBB_0000, 5'd12);
    @(posedge clk);
    @(negedge clk);
    bus.mem_stall_i = 1'b1;
    @(posedge clk);
    #1;
    chk("seqC held", bus.current_inst_address_o, 32'h180);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("seqC rst inst_addr", bus.current_inst_address_o, 32'h0);
    chk("seqC rst wdata", bus.mem_wdata_o, 32'h0);
    chk("seqC rst wd", 32'(bus.mem_wd_o), 32'h0);
    chk("seqC rst wreg", 32'(bus.mem_wreg_o), 32'h0);
    chk("seqC rst delayslot", 32'(bus.is_in_delayslot_o), 32'h0);
    chk("seqC rst new_pc", bus.new_pc_o, 32'h20);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_stall_i = 1'b0;
    clear_ex();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
